// File: rtl/fifo_buf_writer_pkg.sv
// Shared definitions for the imager readout buffer: FSM encodings and default geometry.
// Also imported by the read-side timing block and the imager top-level wrapper.
package fifo_buf_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    localparam int DEF_PIX_W       = 16;
    localparam int DEF_PACK        = 2;
    localparam int DEF_BLOCK_WORDS = 256;
    localparam int DEF_CNT_W       = 16;

    // Lane index width; keeps a one-bit index even when PACK==1.
    function automatic int idx_width(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

endpackage

// File: rtl/fifo_buf_writer_pix_packer.sv
// Packs PIX_W samples into PACK lanes, sample 0 in the LSBs.
// Lanes are zeroed after every completed word so a partial word is already zero-padded.
module pix_packer
    import fifo_buf_writer_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int PACK  = DEF_PACK
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    capture,
    input  logic                    pix_valid,
    input  logic [PIX_W-1:0]        pix_data,
    output logic [PIX_W*PACK-1:0]   word,
    output logic                    word_done,
    output logic                    partial
);

    localparam int IDX_W = idx_width(PACK);

    logic [PACK-1:0][PIX_W-1:0] lane_q, lane_d, lane_fill;
    logic [IDX_W-1:0]           idx_q, idx_d;

    // lane_fill is the word including this cycle's sample; word is taken from it on completion.
    always_comb begin
        lane_fill = lane_q;
        lane_d    = lane_q;
        idx_d     = idx_q;
        word_done = 1'b0;
        if (capture && pix_valid) begin
            lane_fill[idx_q] = pix_data;
            word_done        = (idx_q == IDX_W'(PACK - 1));
            if (word_done) begin
                lane_d = '0;
                idx_d  = '0;
            end else begin
                lane_d = lane_fill;
                idx_d  = idx_q + IDX_W'(1);
            end
        end
        if (clear) begin
            lane_d = '0;
            idx_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
            idx_q  <= '0;
        end else begin
            lane_q <= lane_d;
            idx_q  <= idx_d;
        end
    end

    assign word    = lane_fill;
    assign partial = (idx_q != '0);

endmodule

// File: rtl/fifo_buf_writer.sv
// Write side of the imager readout buffer: frame FSM, FIFO commit with full-drop,
// saturating word counter and per-block flag generation.
module fifo_buf_writer
    import fifo_buf_writer_pkg::*;
#(
    parameter int PIX_W       = DEF_PIX_W,
    parameter int PACK        = DEF_PACK,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                  fifo_wr_clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic                  pix_valid,
    input  logic [PIX_W-1:0]      pix_data,
    input  logic                  fifo_full,
    output logic [PIX_W*PACK-1:0] fifo_din,
    output logic                  fifo_wr_en,
    output logic                  flag,
    output logic                  overflow,
    output logic                  busy,
    output logic [CNT_W-1:0]      word_count
);

    localparam int FIFO_W = PIX_W * PACK;
    localparam int BLK_W  = $clog2(BLOCK_WORDS + 1);

    state_e state_q, state_d;
    logic   start_frame, capturing, flushing;

    logic [FIFO_W-1:0] word;
    logic              word_done, partial;

    logic [FIFO_W-1:0] fifo_din_q, fifo_din_d;
    logic              wr_en_q, wr_en_d, flag_q, flag_d, ovf_q, ovf_d;
    logic [CNT_W-1:0]  wc_q, wc_d;
    logic [BLK_W-1:0]  blk_q, blk_d, blk_inc, blk_after;
    logic              commit_req, commit, blk_wrap;

    always_ff @(posedge fifo_wr_clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (frame_start) state_d = ST_CAPTURE;
            ST_CAPTURE: if (frame_end)   state_d = ST_FLUSH;
            ST_FLUSH:                    state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_frame = (state_q == ST_IDLE) && frame_start;
        capturing   = (state_q == ST_CAPTURE);
        flushing    = (state_q == ST_FLUSH);
        busy        = (state_q != ST_IDLE);
    end

    pix_packer #(.PIX_W(PIX_W), .PACK(PACK)) u_packer (
        .clk       (fifo_wr_clk),
        .rst       (rst),
        .clear     (start_frame || flushing),
        .capture   (capturing),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .word      (word),
        .word_done (word_done),
        .partial   (partial)
    );

    // blk_after is the block count once this cycle's commit (if any) lands; FLUSH flags any remainder.
    always_comb begin
        commit_req = (capturing && word_done) || (flushing && partial);
        commit     = commit_req && !fifo_full;
        blk_inc    = blk_q + BLK_W'(1);
        blk_wrap   = commit && (blk_inc == BLK_W'(BLOCK_WORDS));
        blk_after  = !commit ? blk_q : (blk_wrap ? '0 : blk_inc);

        fifo_din_d = commit ? word : fifo_din_q;
        wr_en_d    = commit;
        flag_d     = blk_wrap || (flushing && blk_after != '0);
        blk_d      = flushing ? '0 : blk_after;
        ovf_d      = ovf_q || (commit_req && fifo_full);
        wc_d       = (commit && wc_q != '1) ? wc_q + CNT_W'(1) : wc_q;
        if (start_frame) begin
            blk_d = '0;
            ovf_d = 1'b0;
            wc_d  = '0;
        end
    end

    always_ff @(posedge fifo_wr_clk or posedge rst) begin
        if (rst) begin
            fifo_din_q <= '0;
            wr_en_q    <= 1'b0;
            flag_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wc_q       <= '0;
            blk_q      <= '0;
        end else begin
            fifo_din_q <= fifo_din_d;
            wr_en_q    <= wr_en_d;
            flag_q     <= flag_d;
            ovf_q      <= ovf_d;
            wc_q       <= wc_d;
            blk_q      <= blk_d;
        end
    end

    assign fifo_din   = fifo_din_q;
    assign fifo_wr_en = wr_en_q;
    assign flag       = flag_q;
    assign overflow   = ovf_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_fifo_buf_writer.sv
// Bench for fifo_buf_writer (PACK=2, BLOCK_WORDS=4, CNT_W=4): vector table, directed corners,
// then random frames against a queue-based reference model.
module tb_fifo_buf_writer;

    localparam int PIX_W = 16;
    localparam int PACK  = 2;
    localparam int BW    = 4;
    localparam int CNT_W = 4;
    localparam int WCMAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start, frame_end, pix_valid, fifo_full;
    logic [15:0] pix_data;
    logic [31:0] fifo_din;
    logic        fifo_wr_en, flag, overflow, busy;
    logic [3:0]  word_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_buf_writer #(.PIX_W(PIX_W), .PACK(PACK), .BLOCK_WORDS(BW), .CNT_W(CNT_W)) dut (
        .fifo_wr_clk (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .fifo_full   (fifo_full),
        .fifo_din    (fifo_din),
        .fifo_wr_en  (fifo_wr_en),
        .flag        (flag),
        .overflow    (overflow),
        .busy        (busy),
        .word_count  (word_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: samples queue + committed-word count ----------------
    int          m_mode;    // 0 idle, 1 capturing, 2 flushing
    logic [15:0] m_pend[$];
    int          m_comm;
    logic        m_ovf;
    logic        e_wr, e_flag;
    logic [31:0] e_din;

    task automatic m_reset();
        m_mode = 0; m_pend.delete(); m_comm = 0; m_ovf = 0;
        e_wr = 0; e_flag = 0; e_din = '0;
    endtask

    function automatic logic [31:0] m_pack();
        logic [31:0] w = '0;
        foreach (m_pend[i]) w[i*16 +: 16] = m_pend[i];
        return w;
    endfunction

    task automatic m_commit(input logic [31:0] w, input logic full);
        if (full) m_ovf = 1;
        else begin
            m_comm++;
            e_wr  = 1;
            e_din = w;
            if (m_comm % BW == 0) e_flag = 1;
        end
    endtask

    task automatic m_step(input logic fs, fe, pv, input logic [15:0] pd, input logic full);
        logic [31:0] w;
        e_wr = 0; e_flag = 0;
        case (m_mode)
            0: if (fs) begin m_mode = 1; m_comm = 0; m_ovf = 0; m_pend.delete(); end
            1: begin
                if (pv) begin
                    m_pend.push_back(pd);
                    if (m_pend.size() == PACK) begin
                        w = m_pack(); m_pend.delete(); m_commit(w, full);
                    end
                end
                if (fe) m_mode = 2;
            end
            default: begin
                if (m_pend.size() > 0) begin
                    w = m_pack(); m_pend.delete(); m_commit(w, full);
                end
                if (m_comm % BW != 0) e_flag = 1;
                m_mode = 0;
            end
        endcase
    endtask

    task automatic chk_model();
        chk("m_wr_en", fifo_wr_en, e_wr);
        if (e_wr) chk("m_din", fifo_din, e_din);
        chk("m_flag", flag, e_flag);
        chk("m_ovf", overflow, m_ovf);
        chk("m_wc", word_count, (m_comm > WCMAX) ? WCMAX : m_comm);
        chk("m_busy", busy, m_mode != 0);
    endtask

    // Drive one cycle of inputs, advance the model, sample just after the edge.
    task automatic apply(input logic fs, fe, pv, input logic [15:0] pd, input logic full);
        frame_start = fs; frame_end = fe; pix_valid = pv; pix_data = pd; fifo_full = full;
        m_step(fs, fe, pv, pd, full);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_start = 0; frame_end = 0; pix_valid = 0; pix_data = '0; fifo_full = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic fs, fe, pv; logic [15:0] pd; logic full;
        logic wr; logic [31:0] din; logic flg, ovf; logic [3:0] wc; logic bsy;
    } vec_t;

    function automatic vec_t v(input logic fs, fe, pv, input logic [15:0] pd, input logic full,
                               input logic wr, input logic [31:0] din, input logic flg, ovf,
                               input logic [3:0] wc, input logic bsy);
        vec_t r;
        r.fs = fs; r.fe = fe; r.pv = pv; r.pd = pd; r.full = full;
        r.wr = wr; r.din = din; r.flg = flg; r.ovf = ovf; r.wc = wc; r.bsy = bsy;
        return r;
    endfunction

    vec_t vt[32];

    initial begin
        int nw;
        // frame: 9 samples, flush pads the 9th; flag on 4th word and on the partial block
        vt[0]  = v(1,0,0,16'h0000,0, 0,32'h0,0,0,0,1);
        vt[1]  = v(0,0,1,16'h0001,0, 0,32'h0,0,0,0,1);
        vt[2]  = v(0,0,1,16'h0002,0, 1,32'h00020001,0,0,1,1);
        vt[3]  = v(0,0,1,16'h0003,0, 0,32'h0,0,0,1,1);
        vt[4]  = v(0,0,1,16'h0004,0, 1,32'h00040003,0,0,2,1);
        vt[5]  = v(0,0,1,16'h0005,0, 0,32'h0,0,0,2,1);
        vt[6]  = v(0,0,1,16'h0006,0, 1,32'h00060005,0,0,3,1);
        vt[7]  = v(0,0,1,16'h0007,0, 0,32'h0,0,0,3,1);
        vt[8]  = v(0,0,1,16'h0008,0, 1,32'h00080007,1,0,4,1);
        vt[9]  = v(0,1,1,16'h0009,0, 0,32'h0,0,0,4,1);
        vt[10] = v(0,0,0,16'h0000,0, 1,32'h00000009,1,0,5,0);
        vt[11] = v(0,0,0,16'h0000,0, 0,32'h0,0,0,5,0);
        // frame: 3rd word completes while full -> dropped, sticky overflow, flush flags remainder only
        vt[12] = v(1,0,0,16'h0000,0, 0,32'h0,0,0,0,1);
        vt[13] = v(0,0,1,16'h000A,0, 0,32'h0,0,0,0,1);
        vt[14] = v(0,0,1,16'h000B,0, 1,32'h000B000A,0,0,1,1);
        vt[15] = v(0,0,1,16'h000C,0, 0,32'h0,0,0,1,1);
        vt[16] = v(0,0,1,16'h000D,0, 1,32'h000D000C,0,0,2,1);
        vt[17] = v(0,0,1,16'h000E,0, 0,32'h0,0,0,2,1);
        vt[18] = v(0,0,1,16'h000F,1, 0,32'h0,0,1,2,1);
        vt[19] = v(0,1,0,16'h0000,0, 0,32'h0,0,1,2,1);
        vt[20] = v(0,0,0,16'h0000,0, 0,32'h0,1,1,2,0);
        vt[21] = v(0,0,0,16'h0000,0, 0,32'h0,0,1,2,0);
        // new frame clears overflow; frame_start in CAPTURE ignored; pix_valid in IDLE ignored
        vt[22] = v(1,0,0,16'h0000,0, 0,32'h0,0,0,0,1);
        vt[23] = v(1,0,1,16'h0011,0, 0,32'h0,0,0,0,1);
        vt[24] = v(0,0,1,16'h0022,0, 1,32'h00220011,0,0,1,1);
        vt[25] = v(0,1,0,16'h0000,0, 0,32'h0,0,0,1,1);
        vt[26] = v(0,0,0,16'h0000,0, 0,32'h0,1,0,1,0);
        vt[27] = v(0,0,1,16'h0033,0, 0,32'h0,0,0,1,0);
        // empty frame: no write, no flag
        vt[28] = v(1,0,0,16'h0000,0, 0,32'h0,0,0,0,1);
        vt[29] = v(0,1,0,16'h0000,0, 0,32'h0,0,0,0,1);
        vt[30] = v(0,0,0,16'h0000,0, 0,32'h0,0,0,0,0);
        vt[31] = v(0,0,0,16'h0000,0, 0,32'h0,0,0,0,0);

        rst = 1'b1;
        frame_start = 0; frame_end = 0; pix_valid = 0; pix_data = '0; fifo_full = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_flag", flag, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wc", word_count, 0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            apply(vt[i].fs, vt[i].fe, vt[i].pv, vt[i].pd, vt[i].full);
            chk($sformatf("v%0d_wr_en", i), fifo_wr_en, vt[i].wr);
            if (vt[i].wr) chk($sformatf("v%0d_din", i), fifo_din, vt[i].din);
            chk($sformatf("v%0d_flag", i), flag, vt[i].flg);
            chk($sformatf("v%0d_ovf", i), overflow, vt[i].ovf);
            chk($sformatf("v%0d_wc", i), word_count, vt[i].wc);
            chk($sformatf("v%0d_busy", i), busy, vt[i].bsy);
        end

        // async reset mid-CAPTURE with one sample pending
        apply(1,0,0,16'h0,0);
        apply(0,0,1,16'h0001,0);
        apply(0,0,1,16'h0002,0);
        apply(0,0,1,16'h0003,0);
        #2 rst = 1'b1;
        #1;
        chk("arst_din", fifo_din, 0);
        chk("arst_wc", word_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_wr_en", fifo_wr_en, 0);
        chk("arst_flag", flag, 0);
        chk("arst_ovf", overflow, 0);
        @(posedge clk); #1 rst = 1'b0;
        m_reset();
        for (int i = 0; i < 4; i++) begin
            apply(0, i == 1, 1, 16'h0004 + 16'(i), 0);
            chk("post_rst_wr_en", fifo_wr_en, 0);
            chk("post_rst_flag", flag, 0);
            chk("post_rst_busy", busy, 0);
        end

        // 8 words: flag exactly with 4th and 8th write, then empty flush
        apply(1,0,0,16'h0,0);
        nw = 0;
        for (int i = 0; i < 16; i++) begin
            apply(0,0,1,16'h0100 + 16'(i),0);
            if (fifo_wr_en) begin
                nw++;
                chk($sformatf("blk_flag_w%0d", nw), flag, (nw % 4) == 0);
            end else chk("blk_flag_idle", flag, 0);
        end
        chk("blk_words", nw, 8);
        chk("blk_wc", word_count, 8);
        apply(0,1,0,16'h0,0);
        apply(0,0,0,16'h0,0);
        chk("blk_flush_wr", fifo_wr_en, 0);
        chk("blk_flush_flag", flag, 0);
        chk("blk_flush_busy", busy, 0);

        // random frames against the model (includes word_count saturation)
        do_reset();
        for (int f = 0; f < 30; f++) begin
            int len;
            len = $urandom_range(0, 50);
            apply(1, 0, $urandom_range(0,1), 16'($urandom), 0);
            chk_model();
            for (int c = 0; c < len; c++) begin
                apply($urandom_range(0,19) == 0, 0, $urandom_range(0,9) < 7,
                      16'($urandom), $urandom_range(0,6) == 0);
                chk_model();
            end
            apply(0, 1, $urandom_range(0,1), 16'($urandom), $urandom_range(0,6) == 0);
            chk_model();
            apply(0, 0, $urandom_range(0,1), 16'($urandom), $urandom_range(0,4) == 0);
            chk_model();
            for (int c = 0; c < int'($urandom_range(0,2)); c++) begin
                apply(0, $urandom_range(0,1), $urandom_range(0,1), 16'($urandom), $urandom_range(0,1));
                chk_model();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
